// File: rtl/gpio_spi_flash_target.sv
// SPI mode-0 target that emulates a tiny serial flash backed by on-chip memory.
// All SPI pins are oversampled by EXTERNAL_CLK; minimum SCK phase width is 4 clocks.
module gpio_spi_flash_target #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter logic [7:0]  ID_BYTE0    = 8'hC2,
  parameter logic [7:0]  ID_BYTE1    = 8'h20,
  parameter logic [7:0]  ID_BYTE2    = 8'h08,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic EXTERNAL_CLK,
  input  logic reset,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic wel,
  output logic cmd_error
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRead,
    StWrite,
    StStatus,
    StRdid,
    StIgnore
  } state_e;

  localparam logic [7:0] OpRead  = 8'h03;
  localparam logic [7:0] OpWrite = 8'h02;
  localparam logic [7:0] OpRdsr  = 8'h05;
  localparam logic [7:0] OpRdid  = 8'h9F;
  localparam logic [7:0] OpWren  = 8'h06;
  localparam logic [7:0] OpWrdi  = 8'h04;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_rise, cs_fall, sck_rise, sck_fall;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_in_q, shift_in_d;
  logic [7:0] shift_out_q, shift_out_d;
  logic [7:0] addr_q, addr_d;
  logic       wel_q, wel_d;
  logic       is_read_q, is_read_d;
  logic       rd_req_q, rd_req_d;
  logic       miso_q, miso_d;
  logic       cmd_err_q, cmd_err_d;
  logic [1:0] id_idx_q, id_idx_d;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       mem_we;

  logic [7:0] mem_q [MEM_DEPTH];

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  assign rx_byte   = {shift_in_q[6:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge EXTERNAL_CLK) begin
    if (reset) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    wel_d       = wel_q;
    is_read_d   = is_read_q;
    rd_req_d    = 1'b0;
    miso_d      = miso_q;
    cmd_err_d   = 1'b0;
    id_idx_d    = id_idx_q;
    mem_we      = 1'b0;

    if (cs_s) begin
      // Deselect wins over any coincident SCK edge; a partial byte is simply dropped.
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b1;
      if (cs_rise && (state_q == StWrite)) begin
        wel_d = 1'b0;
      end
    end else if (state_q == StIdle) begin
      if (cs_fall) begin
        state_d   = StCmd;
        bit_cnt_d = 3'd0;
      end
    end else begin
      if (sck_rise) begin
        shift_in_d = rx_byte;
        bit_cnt_d  = bit_cnt_q + 3'd1;
      end

      if (sck_fall) begin
        if (state_q == StRead || state_q == StStatus || state_q == StRdid) begin
          miso_d = shift_out_q[7];
        end else begin
          miso_d = 1'b1;
        end
        shift_out_d = {shift_out_q[6:0], 1'b1};
      end

      // Memory read issued the cycle after the address changes lands here.
      if (rd_req_q) begin
        shift_out_d = mem_q[addr_q];
      end

      if (byte_done) begin
        case (state_q)
          StCmd: begin
            case (rx_byte)
              OpRead: begin
                state_d   = StAddr;
                is_read_d = 1'b1;
              end
              OpWrite: begin
                state_d   = StAddr;
                is_read_d = 1'b0;
              end
              OpRdsr: begin
                state_d     = StStatus;
                shift_out_d = {6'b0, wel_q, 1'b0};
              end
              OpRdid: begin
                state_d     = StRdid;
                shift_out_d = ID_BYTE0;
                id_idx_d    = 2'd1;
              end
              OpWren: begin
                wel_d   = 1'b1;
                state_d = StIgnore;
              end
              OpWrdi: begin
                wel_d   = 1'b0;
                state_d = StIgnore;
              end
              default: begin
                cmd_err_d = 1'b1;
                state_d   = StIgnore;
              end
            endcase
          end
          StAddr: begin
            addr_d   = rx_byte;
            state_d  = is_read_q ? StRead : StWrite;
            rd_req_d = is_read_q;
          end
          StRead: begin
            addr_d   = addr_q + 8'd1;
            rd_req_d = 1'b1;
          end
          StWrite: begin
            mem_we = wel_q;
            addr_d = addr_q + 8'd1;
          end
          StStatus: begin
            shift_out_d = {6'b0, wel_q, 1'b0};
          end
          StRdid: begin
            case (id_idx_q)
              2'd1:    shift_out_d = ID_BYTE1;
              2'd2:    shift_out_d = ID_BYTE2;
              default: shift_out_d = 8'hFF;
            endcase
            if (id_idx_q != 2'd3) begin
              id_idx_d = id_idx_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge EXTERNAL_CLK) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'hFF;
      addr_q      <= 8'h00;
      wel_q       <= 1'b0;
      is_read_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      miso_q      <= 1'b1;
      cmd_err_q   <= 1'b0;
      id_idx_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      wel_q       <= wel_d;
      is_read_q   <= is_read_d;
      rd_req_q    <= rd_req_d;
      miso_q      <= miso_d;
      cmd_err_q   <= cmd_err_d;
      id_idx_q    <= id_idx_d;
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge EXTERNAL_CLK) begin
    if (mem_we && !reset) begin
      mem_q[addr_q] <= rx_byte;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_s;
  assign wel         = wel_q;
  assign cmd_error   = cmd_err_q;

endmodule

// File: tb/tb_gpio_spi_flash_target.sv
// Directed bench for gpio_spi_flash_target: bit-banged SPI transactions with fixed expectations.
`timescale 1ns / 1ps
module tb_gpio_spi_flash_target;

  logic clk = 1'b0;
  logic reset, cs_n, sck, mosi;
  logic miso, miso_oe, wel, cmd_error;

  int checks = 0;
  int errors = 0;
  int err_cycles = 0;

  gpio_spi_flash_target dut (
    .EXTERNAL_CLK(clk),
    .reset       (reset),
    .spi_cs_n    (cs_n),
    .spi_sck     (sck),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (miso_oe),
    .wel         (wel),
    .cmd_error   (cmd_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_error === 1'b1) err_cycles++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi = tx[7-i];
      repeat (8) @(negedge clk);
      sck = 1'b1;
      rx  = {rx[6:0], miso};
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_lo();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_hi();
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] op);
    logic [7:0] rx;
    cs_lo();
    spi_bits(op, 8, rx);
    cs_hi();
  endtask

  task automatic write2(input logic [7:0] a, input logic [7:0] d0);
    logic [7:0] rx;
    cs_lo();
    spi_bits(8'h02, 8, rx);
    spi_bits(a, 8, rx);
    spi_bits(d0, 8, rx);
    cs_hi();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    cs_n  = 1'b1;
    sck   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso got %b want 1", miso); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", miso_oe); end
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL reset_wel got %b want 0", wel); end
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL reset_cmd_error got %b want 0", cmd_error); end
    cs_lo();
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL oe_selected got %b want 1", miso_oe); end
    cs_hi();
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL oe_deselected got %b want 0", miso_oe); end
  endtask

  task automatic test_write_enable_write();
    logic [7:0] rx;
    send1(8'h06);
    checks++; if (wel !== 1'b1) begin errors++; $display("FAIL wren_wel got %b want 1", wel); end
    cs_lo();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'hAB, 8, rx);
    spi_bits(8'hCD, 8, rx);
    cs_hi();
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL write_end_wel got %b want 0", wel); end
  endtask

  task automatic test_readback();
    logic [7:0] rx;
    int e0;
    e0 = err_cycles;
    cs_lo();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'hAB) begin errors++; $display("FAIL read_0x10 got %h want ab", rx); end
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'hCD) begin errors++; $display("FAIL read_0x11 got %h want cd", rx); end
    cs_hi();
    checks++; if (err_cycles !== e0) begin errors++; $display("FAIL read_no_cmd_error got %0d want %0d", err_cycles, e0); end
  endtask

  task automatic test_write_no_enable();
    logic [7:0] rx;
    send1(8'h06);
    write2(8'h20, 8'h11);
    pulse_reset();
    write2(8'h20, 8'h55);
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL noen_wel got %b want 0", wel); end
    cs_lo();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_hi();
    checks++; if (rx !== 8'h11) begin errors++; $display("FAIL noen_mem got %h want 11", rx); end
    cs_lo();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_hi();
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL status_clear got %h want 00", rx); end
    send1(8'h06);
    cs_lo();
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'h02) begin errors++; $display("FAIL status_wel got %h want 02", rx); end
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'h02) begin errors++; $display("FAIL status_repeat got %h want 02", rx); end
    cs_hi();
    send1(8'h04);
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL wrdi_wel got %b want 0", wel); end
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    send1(8'h06);
    cs_lo();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_hi();
    cs_lo();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL wrap_0xff got %h want ff", rx); end
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap_0x00 got %h want 00", rx); end
    cs_hi();
  endtask

  task automatic test_rdid();
    logic [7:0] rx;
    logic [7:0] exp [4];
    exp[0] = 8'hC2; exp[1] = 8'h20; exp[2] = 8'h08; exp[3] = 8'hFF;
    cs_lo();
    spi_bits(8'h9F, 8, rx);
    for (int i = 0; i < 4; i++) begin
      spi_bits(8'h00, 8, rx);
      checks++;
      if (rx !== exp[i]) begin
        errors++; $display("FAIL rdid_byte%0d got %h want %h", i, rx, exp[i]);
      end
    end
    cs_hi();
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx;
    int e0;
    e0 = err_cycles;
    cs_lo();
    spi_bits(8'h77, 8, rx);
    spi_bits(8'hA5, 8, rx);
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL bad_op_miso got %h want ff", rx); end
    cs_hi();
    checks++; if (err_cycles !== e0 + 1) begin
      errors++; $display("FAIL bad_op_pulse got %0d cycles want 1", err_cycles - e0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    send1(8'h06);
    write2(8'h30, 8'h5A);
    send1(8'h06);
    cs_lo();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h30, 8, rx);
    spi_bits(8'h99, 5, rx);
    cs_hi();
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL abort_wel got %b want 0", wel); end
    cs_lo();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h30, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_hi();
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL abort_mem got %h want 5a", rx); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    send1(8'h06);
    checks++; if (wel !== 1'b1) begin errors++; $display("FAIL pre_reset_wel got %b want 1", wel); end
    cs_lo();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h00, 3, rx);
    @(negedge clk);
    reset = 1'b1;
    cs_n  = 1'b1;
    sck   = 1'b0;
    @(negedge clk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL midrst_miso got %b want 1", miso); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe got %b want 0", miso_oe); end
    checks++; if (wel !== 1'b0) begin errors++; $display("FAIL midrst_wel got %b want 0", wel); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    cs_lo();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_hi();
    checks++; if (rx !== 8'hAB) begin errors++; $display("FAIL post_reset_read got %h want ab", rx); end
  endtask

  initial begin
    test_reset();
    test_write_enable_write();
    test_readback();
    test_write_no_enable();
    test_wrap();
    test_rdid();
    test_bad_opcode();
    test_abort();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_spi_flash_target.md
Name: gpio_spi_flash_target

Overview:
- Synthesizable SPI mode-0 target. It emulates a tiny serial flash/EEPROM backed by 256x8 on-chip memory.
- It sits on the board-side end of the Hack SoC's bit-banged GPIO SPI bus: FLASH_SSB, FLASH_SCK and FLASH_IO0 are driven from gpio[0..2], and MISO returns to the SoC.
- It lets Hack programs exercise SPI software without an external flash part.
- All SPI inputs are asynchronous and are oversampled by EXTERNAL_CLK.

Parameters:
- MEM_DEPTH, 256, number of bytes of backing memory; address is 8 bits and wraps modulo 256.
- ID_BYTE0, 8'hC2, first byte returned by the 0x9F read-ID command.
- ID_BYTE1, 8'h20, second ID byte.
- ID_BYTE2, 8'h08, third ID byte.
- SYNC_STAGES, 2, synchronizer depth on spi_cs_n, spi_sck and spi_mosi.

Ports:
- EXTERNAL_CLK  in  1  system clock, 12 MHz.
- reset  in  1  synchronous, active-high.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_sck  in  1  SPI clock, mode 0 (idle low, sample on rising, shift on falling), asynchronous.
- spi_mosi  in  1  controller-to-target data, MSB first.
- spi_miso  out  1  target-to-controller data.
- spi_miso_oe  out  1  high while spi_cs_n is low (synchronized).
- wel  out  1  write-enable latch status.
- cmd_error  out  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- **Reset values:** spi_miso=1, spi_miso_oe=0, wel=0, cmd_error=0. State=IDLE, bit counter=0, address=0. Memory contents are NOT cleared.
- **Synchronization:** cs_n, sck and mosi pass through SYNC_STAGES flops. Edges are detected from the last two synced samples.
- **Timing limits:** SCK high and low phases must each be ≥4 EXTERNAL_CLK cycles. CS_N setup to the first SCK rise must be ≥4 cycles.
- **Sampling and shifting:** mosi is sampled on a detected sck rise. miso shifts on a detected sck fall. The bit counter (0..7) increments per rise and wraps.
- **Idle condition:** synced cs_n high forces state IDLE, bit counter 0 and miso=1 every cycle, regardless of any other event.
- **Partial bytes:** a partial byte pending at CS_N rise is discarded; no memory write occurs.
- **States:** IDLE, CMD, ADDR, READ, WRITE, STATUS, RDID, IGNORE.
  - IDLE -> CMD on cs_n fall.
  - CMD: on the 8th rise the opcode is decoded.
    - 0x03 -> ADDR, read pending.
    - 0x02 -> ADDR, write pending.
    - 0x05 -> STATUS.
    - 0x9F -> RDID.
    - 0x06 sets wel and goes to IGNORE.
    - 0x04 clears wel and goes to IGNORE.
    - Any other opcode pulses cmd_error for 1 cycle and goes to IGNORE.
  - ADDR: on the 8th rise the address is latched, then -> READ or WRITE.
  - READ: a memory read is issued on the cycle after the address latches. The read has 1-cycle latency into the shift register. Bit7 is driven on the next sck fall; later bits follow on each fall. On each byte's 8th rise the address increments (255 -> 0) and the next read is issued. Reads stream indefinitely.
  - WRITE: each complete byte is written to mem[address] on its 8th rise, only if wel=1, and the address then increments with wrap. If wel=0, bytes are consumed and not written. wel clears on the cs_n rise that ends a WRITE transaction, even if zero bytes were written.
  - STATUS: returns {6'b0, wel, 1'b0} repeatedly, MSB first.
  - RDID: returns ID_BYTE0, ID_BYTE1, ID_BYTE2, then 8'hFF thereafter.
  - IGNORE: mosi is ignored, miso=1, state is held until cs_n rises.
- **Output registration:** spi_miso and spi_miso_oe are registered. spi_miso_oe follows synced cs_n with no extra delay.
- **Reset during a transaction:** the block returns to IDLE, clears wel and aborts any pending write. The next cs_n fall is required before a new command is accepted.
- **Simultaneous events:** a cs_n rise and an sck rise detected in the same cycle resolve to cs_n; the bit is dropped.

Test Plan:
- **Write-enable then write:** 0x06 (CS toggle), then 0x02, 0x10, 0xAB, 0xCD -> mem[0x10]=0xAB, mem[0x11]=0xCD. wel=1 after 0x06 and 0 after the final CS rise.
- **Readback:** after the write above, 0x03, 0x10 plus 16 clocks -> miso returns 0xAB, 0xCD. No cmd_error pulse.
- **Write without enable:** fresh reset, 0x02, 0x20, 0x55 -> mem[0x20] unchanged, wel stays 0. Status read 0x05 returns 0x00. After 0x06, status returns 0x02.
- **Address wrap:** with wel=1, write 0xFF, 0x00 to address 0xFF -> mem[0xFF]=0xFF, mem[0x00]=0x00. Read 0x03, 0xFF for 2 bytes -> 0xFF, 0x00.
- **ID and bad opcode:** 0x9F plus 32 clocks -> 0xC2, 0x20, 0x08, 0xFF. Opcode 0x77 -> cmd_error high for exactly 1 cycle, miso=1 until CS rise.
- **Abort cases:** CS rise after 5 bits of a write data byte -> no write, state IDLE. Assert reset mid-read -> miso=1, spi_miso_oe=0, wel=0 on the next cycle. The next transaction decodes normally.
